bcd_ascii_tx: RTL and testbench

Downstream consumer of the BCD encoder. It captures a completed BCD result (digits plus overflow flag) and serialises it as an ASCII byte stream over a valid/ready handshake. The frame is an optional overflow marker, then the digits MS-first with optional leading-zero suppression, then a terminator byte. It feeds the UART/console byte path.

---
 rtl/bcd_ascii_tx.sv | 175 +++++++++++++++++
 tb/tb_bcd_ascii_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_ascii_tx.sv
// BCD result to ASCII byte-stream serialiser: optional '!' overflow marker,
// digits MS-first with optional leading-zero suppression, then a terminator.
module bcd_ascii_tx #(
    parameter int          DIGITS         = 2,
    parameter bit          SUPPRESS_ZEROS = 1'b1,
    parameter logic [7:0]  TERM           = 8'h0A
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic                  done,
    input  logic                  ovfl,
    output logic [7:0]            tdata,
    output logic                  tvalid,
    input  logic                  tready,
    output logic                  busy
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_OVF  = 3'd1,
        S_SKIP = 3'd2,
        S_EMIT = 3'd3,
        S_TERM = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [IDX_W-1:0]       idx_r;
    logic [IDX_W-1:0]       idx_s;
    logic [4*DIGITS-1:0]    bcd_r;
    logic [4*DIGITS-1:0]    bcd_s;
    logic                   ovfl_r;
    logic                   ovfl_s;
    logic                   done_q_r;
    logic                   tvalid_r;
    logic                   tvalid_s;
    logic [7:0]             tdata_r;
    logic [7:0]             tdata_s;
    logic                   busy_r;
    logic                   start_s;
    logic                   hs_s;
    logic [3:0]             cur_digit_s;

    function automatic logic [3:0] digit_at(
        input logic [4*DIGITS-1:0] v,
        input logic [IDX_W-1:0]    i
    );
        return v[4*i +: 4];
    endfunction

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        logic [7:0] a;
        if (d <= 4'd9) begin
            a = 8'h30 + {4'h0, d};
        end else begin
            a = 8'h3F;
        end
        return a;
    endfunction

    assign start_s     = done & ~done_q_r;
    assign hs_s        = tvalid_r & tready;
    assign cur_digit_s = digit_at(bcd_r, idx_r);

    // Next-state, capture and next-output computation; outputs derive from the next state.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        bcd_s    = bcd_r;
        ovfl_s   = ovfl_r;
        tvalid_s = 1'b0;
        tdata_s  = 8'h00;

        case (state_r)
            S_IDLE: begin
                if (start_s) begin
                    bcd_s   = bcd;
                    ovfl_s  = ovfl;
                    idx_s   = IDX_LAST;
                    state_s = ovfl_s ? S_OVF : S_SKIP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_OVF: begin
                if (hs_s) begin
                    state_s = S_SKIP;
                end else begin
                    state_s = S_OVF;
                end
            end
            S_SKIP: begin
                if (SUPPRESS_ZEROS && (cur_digit_s == 4'd0) && (idx_r != IDX_ZERO)) begin
                    idx_s = idx_r - IDX_ONE;
                end else begin
                    state_s = S_EMIT;
                end
            end
            S_EMIT: begin
                if (hs_s) begin
                    if (idx_r == IDX_ZERO) begin
                        state_s = S_TERM;
                    end else begin
                        idx_s = idx_r - IDX_ONE;
                    end
                end else begin
                    state_s = S_EMIT;
                end
            end
            S_TERM: begin
                if (hs_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_TERM;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        case (state_s)
            S_OVF: begin
                tvalid_s = 1'b1;
                tdata_s  = 8'h21;
            end
            S_EMIT: begin
                tvalid_s = 1'b1;
                tdata_s  = to_ascii(digit_at(bcd_s, idx_s));
            end
            S_TERM: begin
                tvalid_s = 1'b1;
                tdata_s  = TERM;
            end
            default: begin
                tvalid_s = 1'b0;
                tdata_s  = 8'h00;
            end
        endcase
    end

    // State, capture and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            idx_r    <= IDX_ZERO;
            bcd_r    <= '0;
            ovfl_r   <= 1'b0;
            done_q_r <= 1'b0;
            tvalid_r <= 1'b0;
            tdata_r  <= 8'h00;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            bcd_r    <= bcd_s;
            ovfl_r   <= ovfl_s;
            done_q_r <= done;
            tvalid_r <= tvalid_s;
            tdata_r  <= tdata_s;
            busy_r   <= (state_s != S_IDLE);
        end
    end

    assign tvalid = tvalid_r;
    assign tdata  = tdata_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_bcd_ascii_tx.sv
// Directed self-checking bench for bcd_ascii_tx: one instance with leading-zero
// suppression and one without, driven by the same stimulus.
module tb_bcd_ascii_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bcd;
    logic       done;
    logic       ovfl;
    logic       tready;
    logic [7:0] tdata0, tdata1;
    logic       tvalid0, tvalid1;
    logic       busy0, busy1;

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    bcd_ascii_tx #(.DIGITS(2), .SUPPRESS_ZEROS(1'b1), .TERM(8'h0A)) dut (
        .clk(clk), .rst(rst), .bcd(bcd), .done(done), .ovfl(ovfl),
        .tdata(tdata0), .tvalid(tvalid0), .tready(tready), .busy(busy0)
    );

    bcd_ascii_tx #(.DIGITS(2), .SUPPRESS_ZEROS(1'b0), .TERM(8'h0A)) dut_nz (
        .clk(clk), .rst(rst), .bcd(bcd), .done(done), .ovfl(ovfl),
        .tdata(tdata1), .tvalid(tvalid1), .tready(tready), .busy(busy1)
    );

    // Byte collectors: a byte is taken when valid and ready are both up ahead of the edge.
    always @(negedge clk) begin
        if (!rst && tvalid0 && tready) q0.push_back(tdata0);
        if (!rst && tvalid1 && tready) q1.push_back(tdata1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] v, input logic o);
        bcd  = v;
        ovfl = o;
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy1) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (busy0 || busy1) begin
            errors++;
            $display("FAIL idle_timeout busy0=%0b busy1=%0b expected 0", busy0, busy1);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++; if (tvalid0 !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b expected 0", tvalid0); end
        checks++; if (tdata0 !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h expected 00", tdata0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", busy0); end
        checks++; if (tvalid1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_nz got v=%0b b=%0b expected 0 0", tvalid1, busy1); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] e[$];
        q0.delete(); q1.delete();
        tready = 1'b1;
        bcd = 8'h42; ovfl = 1'b0; done = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (tvalid0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL basic_skip_cycle got v=%0b b=%0b expected v=0 b=1", tvalid0, busy0); end
        tick();
        done = 1'b0;
        @(negedge clk);
        checks++; if (tvalid0 !== 1'b1 || tdata0 !== 8'h34) begin errors++; $display("FAIL basic_first_byte got v=%0b d=%h expected v=1 d=34", tvalid0, tdata0); end
        wait_idle();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %0b expected 0", busy0); end
        e = '{8'h34, 8'h32, 8'h0A};
        checks++;
        if (q0.size() != e.size()) begin errors++; $display("FAIL basic_len got %0d expected %0d", q0.size(), e.size()); end
        else for (int i = 0; i < e.size(); i++) begin checks++; if (q0[i] !== e[i]) begin errors++; $display("FAIL basic_byte%0d got %h expected %h", i, q0[i], e[i]); end end
        checks++;
        if (q1.size() != e.size()) begin errors++; $display("FAIL basic_nz_len got %0d expected %0d", q1.size(), e.size()); end
        else for (int i = 0; i < e.size(); i++) begin checks++; if (q1[i] !== e[i]) begin errors++; $display("FAIL basic_nz_byte%0d got %h expected %h", i, q1[i], e[i]); end end
    endtask

    task automatic test_suppress();
        logic [7:0] e0[$];
        logic [7:0] e1[$];
        int lat;
        q0.delete(); q1.delete();
        tready = 1'b1;
        // 07: one suppressed digit delays the first byte by one extra cycle
        bcd = 8'h07; ovfl = 1'b0; done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        @(negedge clk);
        checks++; if (tvalid0 !== 1'b0) begin errors++; $display("FAIL sup_latency_early got %0b expected 0", tvalid0); end
        checks++; if (tvalid1 !== 1'b1 || tdata1 !== 8'h30) begin errors++; $display("FAIL nz_first_byte got v=%0b d=%h expected v=1 d=30", tvalid1, tdata1); end
        tick();
        @(negedge clk);
        checks++; if (tvalid0 !== 1'b1 || tdata0 !== 8'h37) begin errors++; $display("FAIL sup_first_byte got v=%0b d=%h expected v=1 d=37", tvalid0, tdata0); end
        wait_idle();
        e0 = '{8'h37, 8'h0A};
        e1 = '{8'h30, 8'h37, 8'h0A};
        checks++;
        if (q0.size() != e0.size()) begin errors++; $display("FAIL sup07_len got %0d expected %0d", q0.size(), e0.size()); end
        else for (int i = 0; i < e0.size(); i++) begin checks++; if (q0[i] !== e0[i]) begin errors++; $display("FAIL sup07_byte%0d got %h expected %h", i, q0[i], e0[i]); end end
        checks++;
        if (q1.size() != e1.size()) begin errors++; $display("FAIL nz07_len got %0d expected %0d", q1.size(), e1.size()); end
        else for (int i = 0; i < e1.size(); i++) begin checks++; if (q1[i] !== e1[i]) begin errors++; $display("FAIL nz07_byte%0d got %h expected %h", i, q1[i], e1[i]); end end
        // 00: LS digit always emitted
        q0.delete(); q1.delete();
        pulse(8'h00, 1'b0);
        wait_idle();
        e0 = '{8'h30, 8'h0A};
        e1 = '{8'h30, 8'h30, 8'h0A};
        checks++;
        if (q0.size() != e0.size()) begin errors++; $display("FAIL sup00_len got %0d expected %0d", q0.size(), e0.size()); end
        else for (int i = 0; i < e0.size(); i++) begin checks++; if (q0[i] !== e0[i]) begin errors++; $display("FAIL sup00_byte%0d got %h expected %h", i, q0[i], e0[i]); end end
        checks++;
        if (q1.size() != e1.size()) begin errors++; $display("FAIL nz00_len got %0d expected %0d", q1.size(), e1.size()); end
        else for (int i = 0; i < e1.size(); i++) begin checks++; if (q1[i] !== e1[i]) begin errors++; $display("FAIL nz00_byte%0d got %h expected %h", i, q1[i], e1[i]); end end
        lat = 0;
    endtask

    task automatic test_ovf_invalid();
        logic [7:0] e[$];
        q0.delete(); q1.delete();
        tready = 1'b1;
        bcd = 8'h15; ovfl = 1'b1; done = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (tvalid0 !== 1'b1 || tdata0 !== 8'h21) begin errors++; $display("FAIL ovf_first_byte got v=%0b d=%h expected v=1 d=21", tvalid0, tdata0); end
        tick();
        done = 1'b0; ovfl = 1'b0;
        wait_idle();
        e = '{8'h21, 8'h31, 8'h35, 8'h0A};
        checks++;
        if (q0.size() != e.size()) begin errors++; $display("FAIL ovf_len got %0d expected %0d", q0.size(), e.size()); end
        else for (int i = 0; i < e.size(); i++) begin checks++; if (q0[i] !== e[i]) begin errors++; $display("FAIL ovf_byte%0d got %h expected %h", i, q0[i], e[i]); end end
        q0.delete(); q1.delete();
        pulse(8'hA3, 1'b0);
        wait_idle();
        e = '{8'h3F, 8'h33, 8'h0A};
        checks++;
        if (q0.size() != e.size()) begin errors++; $display("FAIL inv_len got %0d expected %0d", q0.size(), e.size()); end
        else for (int i = 0; i < e.size(); i++) begin checks++; if (q0[i] !== e[i]) begin errors++; $display("FAIL inv_byte%0d got %h expected %h", i, q0[i], e[i]); end end
    endtask

    task automatic test_backpressure();
        logic [7:0] e[$];
        q0.delete(); q1.delete();
        tready = 1'b0;
        pulse(8'h42, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (tvalid0 !== 1'b1 || tdata0 !== 8'h34) begin errors++; $display("FAIL bp_hold%0d got v=%0b d=%h expected v=1 d=34", i, tvalid0, tdata0); end
            tick();
        end
        tready = 1'b1;
        wait_idle();
        e = '{8'h34, 8'h32, 8'h0A};
        checks++;
        if (q0.size() != e.size()) begin errors++; $display("FAIL bp_len got %0d expected %0d", q0.size(), e.size()); end
        else for (int i = 0; i < e.size(); i++) begin checks++; if (q0[i] !== e[i]) begin errors++; $display("FAIL bp_byte%0d got %h expected %h", i, q0[i], e[i]); end end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] e[$];
        q0.delete(); q1.delete();
        tready = 1'b0;
        pulse(8'h42, 1'b0);
        pulse(8'h99, 1'b0);
        @(negedge clk);
        checks++; if (busy0 !== 1'b1 || tdata0 !== 8'h34) begin errors++; $display("FAIL ign_busy got b=%0b d=%h expected b=1 d=34", busy0, tdata0); end
        tick();
        tready = 1'b1;
        wait_idle();
        e = '{8'h34, 8'h32, 8'h0A};
        checks++;
        if (q0.size() != e.size()) begin errors++; $display("FAIL ign_len got %0d expected %0d", q0.size(), e.size()); end
        else for (int i = 0; i < e.size(); i++) begin checks++; if (q0[i] !== e[i]) begin errors++; $display("FAIL ign_byte%0d got %h expected %h", i, q0[i], e[i]); end end
        q0.delete(); q1.delete();
        pulse(8'h55, 1'b0);
        wait_idle();
        e = '{8'h35, 8'h35, 8'h0A};
        checks++;
        if (q0.size() != e.size()) begin errors++; $display("FAIL new_len got %0d expected %0d", q0.size(), e.size()); end
        else for (int i = 0; i < e.size(); i++) begin checks++; if (q0[i] !== e[i]) begin errors++; $display("FAIL new_byte%0d got %h expected %h", i, q0[i], e[i]); end end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e[$];
        q0.delete(); q1.delete();
        tready = 1'b0;
        pulse(8'h42, 1'b0);
        @(negedge clk);
        checks++; if (tvalid0 !== 1'b1) begin errors++; $display("FAIL rmid_pre got %0b expected 1", tvalid0); end
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (tvalid0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL rmid_abort got v=%0b b=%0b expected 0 0", tvalid0, busy0); end
        tick();
        rst = 1'b0;
        tready = 1'b1;
        tick();
        q0.delete(); q1.delete();
        pulse(8'h10, 1'b0);
        wait_idle();
        e = '{8'h31, 8'h30, 8'h0A};
        checks++;
        if (q0.size() != e.size()) begin errors++; $display("FAIL rmid_len got %0d expected %0d", q0.size(), e.size()); end
        else for (int i = 0; i < e.size(); i++) begin checks++; if (q0[i] !== e[i]) begin errors++; $display("FAIL rmid_byte%0d got %h expected %h", i, q0[i], e[i]); end end
        checks++;
        if (q1.size() != e.size()) begin errors++; $display("FAIL rmid_nz_len got %0d expected %0d", q1.size(), e.size()); end
        else for (int i = 0; i < e.size(); i++) begin checks++; if (q1[i] !== e[i]) begin errors++; $display("FAIL rmid_nz_byte%0d got %h expected %h", i, q1[i], e[i]); end end
    endtask

    initial begin
        rst    = 1'b1;
        bcd    = 8'h00;
        done   = 1'b0;
        ovfl   = 1'b0;
        tready = 1'b0;
        test_reset();
        test_basic();
        test_suppress();
        test_ovf_invalid();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
